eth_frame_dibit_tx: RTL and testbench

//  Parametrised successor to the dibit frame generator: emits one complete RMII TX frame per start.

---
 rtl/eth_frame_dibit_tx_pkg.sv | 31 +++
 rtl/eth_frame_dibit_tx_crc32_dibit.sv | 30 +++
 rtl/eth_frame_dibit_tx.sv | 227 ++++++++++++++++++++++
 tb/tb_eth_frame_dibit_tx.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_frame_dibit_tx_pkg.sv
// Shared constants, state encoding and CRC step helpers for the dibit frame transmitter.
package eth_frame_dibit_tx_pkg;

    localparam int unsigned BYTE_LEN      = 8;
    localparam int unsigned ETH_HDR_LEN   = 14;
    localparam int unsigned FCS_DIBITS    = 16;
    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_HDR,
        ST_PAY,
        ST_PAD,
        ST_FCS,
        ST_IPG
    } state_e;

    function automatic logic [31:0] crc_step1(input logic [31:0] crc, input logic din);
        if (crc[0] ^ din) return (crc >> 1) ^ CRC_POLY_REFL;
        else              return crc >> 1;
    endfunction

    // Wire order: din[0] leaves first, so it enters the CRC first.
    function automatic logic [31:0] crc_step2(input logic [31:0] crc, input logic [1:0] din);
        return crc_step1(crc_step1(crc, din[0]), din[1]);
    endfunction

endpackage

// File: rtl/eth_frame_dibit_tx_crc32_dibit.sv
// Two-bit-per-cycle reflected CRC-32; shift mode turns the register into the FCS shifter.
module crc32_dibit
    import eth_frame_dibit_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic        shift_i,
    input  logic [1:0]  din_i,
    output logic [31:0] crc_o
);

    logic [31:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clr_i)        crc_d = CRC_INIT;
        else if (shift_i) crc_d = {2'b00, crc_q[31:2]};
        else if (en_i)    crc_d = crc_step2(crc_q, din_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) crc_q <= CRC_INIT;
        else        crc_q <= crc_d;
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/eth_frame_dibit_tx.sv
// Dibit-serial RMII frame generator: preamble/SFD, header from ports, streamed payload,
// zero pad, FCS and inter-packet gap, one frame per accepted start.
module eth_frame_dibit_tx
    import eth_frame_dibit_tx_pkg::*;
#(
    parameter int unsigned PREAMBLE_DIBITS = 32,
    parameter int unsigned MIN_PAYLOAD     = 46,
    parameter int unsigned MAX_PAYLOAD     = 1500,
    parameter int unsigned IPG_DIBITS      = 48
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [47:0] mac_dst_i,
    input  logic [47:0] mac_src_i,
    input  logic [15:0] ethertype_i,
    input  logic        in_valid_i,
    input  logic [7:0]  in_data_i,
    input  logic        in_last_i,
    output logic        in_rdy_o,
    output logic        tx_en_o,
    output logic [1:0]  txd_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        underrun_o,
    output logic        oversize_o
);

    localparam int unsigned HDR_W      = ETH_HDR_LEN * BYTE_LEN;
    localparam int unsigned HDR_DIBITS = HDR_W / 2;
    localparam int unsigned PH_A       = (PREAMBLE_DIBITS > IPG_DIBITS) ? PREAMBLE_DIBITS : IPG_DIBITS;
    localparam int unsigned PH_MAX     = (PH_A > HDR_DIBITS) ? PH_A : HDR_DIBITS;
    localparam int unsigned PH_W       = $clog2(PH_MAX + 1);
    localparam int unsigned PC_W       = $clog2(MAX_PAYLOAD + 1);

    localparam logic [PH_W-1:0] PRE_LAST = PH_W'(PREAMBLE_DIBITS - 1);
    localparam logic [PH_W-1:0] HDR_LAST = PH_W'(HDR_DIBITS - 1);
    localparam logic [PH_W-1:0] FCS_LAST = PH_W'(FCS_DIBITS - 1);
    localparam logic [PH_W-1:0] IPG_LAST = PH_W'(IPG_DIBITS - 1);
    localparam logic [PC_W-1:0] PC_MIN   = PC_W'(MIN_PAYLOAD);
    localparam logic [PC_W-1:0] PC_LIMIT = PC_W'(MAX_PAYLOAD - 1);
    localparam logic [PC_W-1:0] PC_SAT   = '1;

    state_e            state_q, state_d;
    logic [PH_W-1:0]   ph_q, ph_d;
    logic [1:0]        idx_q, idx_d;
    logic [7:0]        byte_q, byte_d;
    logic [HDR_W-1:0]  hdr_q, hdr_d;
    logic [PC_W-1:0]   pay_cnt_q, pay_cnt_d, pay_inc;
    logic              last_q, last_d;
    logic              underrun_q, underrun_d;
    logic              oversize_q, oversize_d;

    logic              crc_clr, crc_en, crc_shift;
    logic [1:0]        crc_lo, ser_dibit;
    logic [29:0]       crc_unused;

    assign ser_dibit = byte_q[{idx_q, 1'b0} +: 2];
    assign pay_inc   = (pay_cnt_q == PC_SAT) ? pay_cnt_q : pay_cnt_q + PC_W'(1);

    always_comb begin
        state_d    = state_q;
        ph_d       = ph_q;
        idx_d      = idx_q;
        byte_d     = byte_q;
        hdr_d      = hdr_q;
        pay_cnt_d  = pay_cnt_q;
        last_d     = last_q;
        underrun_d = 1'b0;
        oversize_d = 1'b0;
        in_rdy_o   = 1'b0;
        tx_en_o    = 1'b0;
        txd_o      = 2'b00;
        crc_clr    = 1'b0;
        crc_en     = 1'b0;
        crc_shift  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d   = ST_PRE;
                    ph_d      = '0;
                    hdr_d     = {mac_dst_i, mac_src_i, ethertype_i};
                    pay_cnt_d = '0;
                    last_d    = 1'b0;
                    crc_clr   = 1'b1;
                end
            end
            ST_PRE: begin
                tx_en_o = 1'b1;
                txd_o   = (ph_q == PRE_LAST) ? 2'b11 : 2'b01;
                ph_d    = ph_q + PH_W'(1);
                if (ph_q == PRE_LAST) begin
                    state_d = ST_HDR;
                    ph_d    = '0;
                    idx_d   = '0;
                    byte_d  = hdr_q[HDR_W-1 -: BYTE_LEN];
                    hdr_d   = {hdr_q[HDR_W-BYTE_LEN-1:0], {BYTE_LEN{1'b0}}};
                end
            end
            ST_HDR: begin
                tx_en_o = 1'b1;
                txd_o   = ser_dibit;
                crc_en  = 1'b1;
                ph_d    = ph_q + PH_W'(1);
                idx_d   = idx_q + 2'd1;
                if (ph_q == HDR_LAST) begin
                    in_rdy_o = 1'b1;
                    ph_d     = '0;
                end else if (idx_q == 2'd3) begin
                    byte_d = hdr_q[HDR_W-1 -: BYTE_LEN];
                    hdr_d  = {hdr_q[HDR_W-BYTE_LEN-1:0], {BYTE_LEN{1'b0}}};
                end
            end
            ST_PAY: begin
                tx_en_o = 1'b1;
                txd_o   = ser_dibit;
                crc_en  = 1'b1;
                idx_d   = idx_q + 2'd1;
                // last_q marks the byte now on the wire as the final one; its tail decides PAD vs FCS.
                if (idx_q == 2'd3) begin
                    if (!last_q) begin
                        in_rdy_o = 1'b1;
                    end else if (pay_cnt_q >= PC_MIN) begin
                        state_d = ST_FCS;
                        ph_d    = '0;
                    end else begin
                        state_d   = ST_PAD;
                        byte_d    = '0;
                        pay_cnt_d = pay_inc;
                    end
                end
            end
            ST_PAD: begin
                tx_en_o = 1'b1;
                txd_o   = ser_dibit;
                crc_en  = 1'b1;
                idx_d   = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    if (pay_cnt_q >= PC_MIN) begin
                        state_d = ST_FCS;
                        ph_d    = '0;
                    end else begin
                        byte_d    = '0;
                        pay_cnt_d = pay_inc;
                    end
                end
            end
            ST_FCS: begin
                tx_en_o   = 1'b1;
                txd_o     = ~crc_lo;
                crc_shift = 1'b1;
                ph_d      = ph_q + PH_W'(1);
                if (ph_q == FCS_LAST) begin
                    state_d = ST_IPG;
                    ph_d    = '0;
                end
            end
            ST_IPG: begin
                ph_d = ph_q + PH_W'(1);
                if (ph_q == IPG_LAST) begin
                    state_d = ST_IDLE;
                    ph_d    = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (in_rdy_o) begin
            if (in_valid_i) begin
                state_d   = ST_PAY;
                byte_d    = in_data_i;
                pay_cnt_d = pay_inc;
                if (in_last_i) begin
                    last_d = 1'b1;
                end else if (pay_cnt_q == PC_LIMIT) begin
                    last_d     = 1'b1;
                    oversize_d = 1'b1;
                end
            end else begin
                state_d    = ST_IPG;
                ph_d       = '0;
                underrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ph_q       <= '0;
            idx_q      <= '0;
            byte_q     <= '0;
            hdr_q      <= '0;
            pay_cnt_q  <= '0;
            last_q     <= 1'b0;
            underrun_q <= 1'b0;
            oversize_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            idx_q      <= idx_d;
            byte_q     <= byte_d;
            hdr_q      <= hdr_d;
            pay_cnt_q  <= pay_cnt_d;
            last_q     <= last_d;
            underrun_q <= underrun_d;
            oversize_q <= oversize_d;
        end
    end

    crc32_dibit u_crc (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (crc_clr),
        .en_i    (crc_en),
        .shift_i (crc_shift),
        .din_i   (txd_o),
        .crc_o   ({crc_unused, crc_lo})
    );

    assign busy_o     = (state_q != ST_IDLE);
    assign done_o     = (state_q == ST_IPG) && (ph_q == IPG_LAST);
    assign underrun_o = underrun_q;
    assign oversize_o = oversize_q;

endmodule

// File: tb/tb_eth_frame_dibit_tx.sv
// Directed scoreboard bench for eth_frame_dibit_tx: expected dibits queued per frame, popped on tx_en.
module tb_eth_frame_dibit_tx;
    import eth_frame_dibit_tx_pkg::*;

    localparam int unsigned PRE  = 32;
    localparam int unsigned MINP = 46;
    localparam int unsigned MAXP = 64;
    localparam int unsigned IPG  = 48;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [47:0] mac_dst = '0;
    logic [47:0] mac_src = '0;
    logic [15:0] ethertype = '0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_last = 1'b0;
    logic        in_rdy_o, tx_en_o, busy_o, done_o, underrun_o, oversize_o;
    logic [1:0]  txd_o;

    always #5 clk = ~clk;

    eth_frame_dibit_tx #(
        .PREAMBLE_DIBITS (PRE),
        .MIN_PAYLOAD     (MINP),
        .MAX_PAYLOAD     (MAXP),
        .IPG_DIBITS      (IPG)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start),
        .mac_dst_i   (mac_dst),
        .mac_src_i   (mac_src),
        .ethertype_i (ethertype),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .in_last_i   (in_last),
        .in_rdy_o    (in_rdy_o),
        .tx_en_o     (tx_en_o),
        .txd_o       (txd_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .underrun_o  (underrun_o),
        .oversize_o  (oversize_o)
    );

    int checks = 0;
    int errors = 0;

    logic [1:0] exp_q[$];
    logic [1:0] rx_q[$];
    logic [7:0] src_q[$];
    bit  src_last, acc_pend, mon_en;
    int  drop_at, accepted, cyc;
    int  rdy_cnt, und_cnt, ovs_cnt, done_cnt, last_tx_cyc, done_cyc, und_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    function automatic logic [31:0] rx_crc_dibit(input logic [31:0] c, input logic [1:0] d);
        logic [31:0] r;
        r = c;
        for (int k = 0; k < 2; k++) r = (r[0] ^ d[k]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    function automatic logic [31:0] bitrev(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    task automatic tick();
        logic [1:0] e;
        @(negedge clk);
        cyc++;
        if (acc_pend) begin
            void'(src_q.pop_front());
            accepted++;
        end
        if (mon_en) begin
            if (tx_en_o) begin
                rx_q.push_back(txd_o);
                last_tx_cyc = cyc;
                if (exp_q.size() == 0) chk("tx_en_beyond_frame", {31'd0, tx_en_o}, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    chk("txd", {30'd0, txd_o}, {30'd0, e});
                end
            end
            if (in_rdy_o) rdy_cnt++;
            if (underrun_o) begin und_cnt++; und_cyc = cyc; end
            if (oversize_o) ovs_cnt++;
            if (done_o) begin done_cnt++; done_cyc = cyc; end
        end
        in_valid = (src_q.size() > 0) && (accepted != drop_at);
        in_data  = (src_q.size() > 0) ? src_q[0] : 8'h00;
        in_last  = src_last && (src_q.size() == 1);
        acc_pend = in_rdy_o && in_valid;
    endtask

    task automatic send_frame(input string name, input logic [47:0] dst, input logic [47:0] srcm,
                              input logic [15:0] typ, input int n_offer, input logic [7:0] base,
                              input bit with_last, input int drop, input bit keep_start);
        logic [7:0]  fb[$];
        logic [7:0]  b;
        logic [31:0] c;
        int n_acc, budget, gap;
        bit abort;
        abort = (drop >= 0);
        n_acc = with_last ? n_offer : ((n_offer < int'(MAXP)) ? n_offer : int'(MAXP));
        if (abort) n_acc = drop;
        for (int i = 0; i < 6; i++) fb.push_back(dst[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) fb.push_back(srcm[47-8*i -: 8]);
        fb.push_back(typ[15:8]);
        fb.push_back(typ[7:0]);
        for (int i = 0; i < n_acc; i++) fb.push_back(base + 8'(i));
        if (!abort) begin
            while (fb.size() < 14 + MINP) fb.push_back(8'h00);
            c = CRC_INIT;
            foreach (fb[i]) c = crc_byte(c, fb[i]);
            c = ~c;
            for (int i = 0; i < 4; i++) fb.push_back(c[8*i +: 8]);
        end
        exp_q.delete();
        rx_q.delete();
        for (int i = 0; i < int'(PRE) - 1; i++) exp_q.push_back(2'b01);
        exp_q.push_back(2'b11);
        foreach (fb[i]) begin
            b = fb[i];
            for (int k = 0; k < 4; k++) exp_q.push_back(b[2*k +: 2]);
        end
        src_q.delete();
        for (int i = 0; i < n_offer; i++) src_q.push_back(base + 8'(i));
        src_last = with_last;
        drop_at  = drop;
        accepted = 0;
        acc_pend = 1'b0;
        rdy_cnt = 0; und_cnt = 0; ovs_cnt = 0; done_cnt = 0;
        last_tx_cyc = 0; done_cyc = 0; und_cyc = 0;
        mon_en    = 1'b1;
        mac_dst   = dst;
        mac_src   = srcm;
        ethertype = typ;
        start     = 1'b1;
        tick();
        if (!keep_start) start = 1'b0;
        budget = 0;
        gap = 0;
        while (done_cnt == 0 && budget < 5000) begin
            if (!busy_o) gap++;
            tick();
            budget++;
        end
        chk({name, "_done_seen"}, done_cnt, 1);
        chk({name, "_busy_at_done"}, {31'd0, busy_o}, 1);
        chk({name, "_busy_gap"}, gap, 0);
        chk({name, "_dibits_left"}, exp_q.size(), 0);
        chk({name, "_wire_dibits"}, rx_q.size(), PRE + 4 * fb.size());
        chk({name, "_rdy_count"}, rdy_cnt, abort ? drop + 1 : n_acc);
        chk({name, "_underrun"}, und_cnt, abort ? 1 : 0);
        chk({name, "_oversize"}, ovs_cnt, (!with_last && !abort && n_offer >= int'(MAXP)) ? 1 : 0);
        chk({name, "_done_after_last_dibit"}, done_cyc - last_tx_cyc, IPG);
        if (abort) chk({name, "_underrun_cycle"}, und_cyc - last_tx_cyc, 1);
        else begin
            c = CRC_INIT;
            for (int i = int'(PRE); i < rx_q.size(); i++) c = rx_crc_dibit(c, rx_q[i]);
            chk({name, "_residue"}, bitrev(c), CRC_RESIDUE);
        end
        src_q.delete();
        acc_pend = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        cyc = 0;
        mon_en = 1'b0;
        drop_at = -1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_tx_en", {31'd0, tx_en_o}, 0);
        chk("rst_txd", {30'd0, txd_o}, 0);
        chk("rst_in_rdy", {31'd0, in_rdy_o}, 0);
        chk("rst_busy", {31'd0, busy_o}, 0);
        chk("rst_done", {31'd0, done_o}, 0);
        chk("rst_underrun", {31'd0, underrun_o}, 0);
        chk("rst_oversize", {31'd0, oversize_o}, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        send_frame("t1", 48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 16'h0800, 46, 8'h00, 1'b1, -1, 1'b0);
        repeat (3) tick();
        send_frame("t2", 48'h0A0B_0C0D_0E0F, 48'h0200_0000_0002, 16'h86DD, 1, 8'h5A, 1'b1, -1, 1'b0);
        repeat (3) tick();
        send_frame("t3", 48'h1122_3344_5566, 48'h0200_0000_0003, 16'h0806, 30, 8'h10, 1'b1, 10, 1'b0);
        repeat (3) tick();
        send_frame("t4", 48'hFFFF_FFFF_FFFF, 48'h0200_0000_0004, 16'h88B5, 80, 8'h80, 1'b0, -1, 1'b0);
        repeat (3) tick();

        mon_en = 1'b0;
        exp_q.delete();
        mac_dst = 48'hDEAD_BEEF_0001;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (PRE + 20) tick();
        chk("t5_tx_en_mid_header", {31'd0, tx_en_o}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_tx_en", {31'd0, tx_en_o}, 0);
        chk("t5_async_busy", {31'd0, busy_o}, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        send_frame("t5", 48'h0102_0304_0506, 48'h0200_0000_0005, 16'h0800, 20, 8'h33, 1'b1, -1, 1'b0);
        repeat (3) tick();

        send_frame("t6a", 48'hFFFF_FFFF_FFFF, 48'h0200_0000_0006, 16'h0800, 50, 8'hC0, 1'b1, -1, 1'b1);
        tick();
        chk("t6_idle_busy", {31'd0, busy_o}, 0);
        chk("t6_idle_tx_en", {31'd0, tx_en_o}, 0);
        send_frame("t6b", 48'h0000_0000_0007, 48'h0200_0000_0007, 16'h0801, 5, 8'hE0, 1'b1, -1, 1'b0);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
